seq_alu: RTL and testbench

- Parametrised WIDTH-bit ALU with valid/ready handshakes on input and output; successor to the fixed 32-bit combinational ripple ALU.
- Single-cycle ops: AND, OR, ADD, SUB, SLT, NOR, XOR. Multi-cycle op: unsigned shift-add multiply.
- Result and flags are registered and held until the consumer accepts them.
- Sits between the register-file read stage and writeback in the datapath.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 37 +++
 rtl/seq_alu_addsub.sv | 34 +++
 rtl/seq_alu.sv | 165 ++++++++++++++++
 tb/tb_seq_alu.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_pkg
// Purpose  : Shared op-code constants and FSM state encoding for seq_alu.
// Revision : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

  // op = {sub, op[1:0]}; bit 2 doubles as the adder's subtract control
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Purpose  : Operand/result handshake bundle for seq_alu.
// Ports    : in_valid/in_ready/a/b/op   - operation request (producer -> ALU)
//            out_valid/out_ready        - result handshake (ALU -> consumer)
//            result/result_hi/zero/cout/overflow - registered result and flags
// Modports : master = producer/consumer side, slave = ALU side
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, result_hi, zero, cout, overflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_alu_addsub.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_addsub
// Purpose  : Combinational WIDTH-bit adder/subtractor shared by ADD/SUB/SLT.
// Ports    : a, b     - operands
//            sub      - 1: compute a - b (b inverted, carry-in 1)
//            sum      - WIDTH-bit wrapped sum
//            cout     - carry out of the MSB (1 = no borrow when subtracting)
//            overflow - signed overflow of the operation
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b      = b ^ {WIDTH{sub}};
  assign w_full   = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};
  assign sum      = w_full[WIDTH-1:0];
  assign cout     = w_full[WIDTH];
  // Same-sign operands producing an opposite-sign sum
  assign overflow = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : WIDTH-bit ALU with valid/ready handshakes. Logic and add/sub ops
//            complete in one cycle; MUL is an iterative unsigned shift-add
//            multiply taking WIDTH iterations. Result and flags are registered
//            and held until the consumer accepts them.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - seq_alu_if slave (request, result and flags)
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  import seq_alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_zero;
  logic               r_cout;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_cout;
  logic               w_alu_ovf;
  logic               w_accept;
  logic               w_mul_end;
  logic [WIDTH:0]     w_part;

  seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (bus.a),
    .b        (bus.b),
    .sub      (bus.op[2]),
    .sum      (w_sum),
    .cout     (w_cout),
    .overflow (w_ovf)
  );

  assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
  // Counter reaches WIDTH one cycle after the last iteration; that cycle
  // transfers the finished product into the output registers.
  assign w_mul_end = (r_state == ST_MUL) && (r_cnt == CNT_W'(WIDTH));
  // Upper accumulator half plus the gated multiplicand, keeping the carry
  assign w_part    = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};

  // Single-cycle operations
  always_comb begin
    w_alu_res  = '0;
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    case (bus.op)
      OP_AND: w_alu_res = bus.a & bus.b;
      OP_OR:  w_alu_res = bus.a | bus.b;
      OP_NOR: w_alu_res = ~(bus.a | bus.b);
      OP_XOR: w_alu_res = bus.a ^ bus.b;
      OP_ADD, OP_SUB: begin
        w_alu_res  = w_sum;
        w_alu_cout = w_cout;
        w_alu_ovf  = w_ovf;
      end
      OP_SLT: begin
        // Sign of the true difference, corrected for overflow
        w_alu_res  = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
        w_alu_cout = w_cout;
        w_alu_ovf  = w_ovf;
      end
      default: w_alu_res = '0;  // MUL goes through the iterative path
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = (bus.op == OP_MUL) ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        if (w_mul_end) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, multiply iterations, output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      if (bus.op == OP_MUL) begin
        r_mcand  <= bus.a;
        r_mplier <= bus.b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_result    <= w_alu_res;
        r_result_hi <= '0;
        r_zero      <= ~|w_alu_res;
        r_cout      <= w_alu_cout;
        r_ovf       <= w_alu_ovf;
      end
    end else if (r_state == ST_MUL) begin
      if (w_mul_end) begin
        r_result    <= r_acc[WIDTH-1:0];
        r_result_hi <= r_acc[2*WIDTH-1:WIDTH];
        r_zero      <= ~|r_acc;
        r_cout      <= 1'b0;
        r_ovf       <= |r_acc[2*WIDTH-1:WIDTH];
      end else begin
        // Shift {carry, upper + addend, lower} right by one
        r_acc    <= {w_part, r_acc[WIDTH-1:1]};
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.zero      = r_zero;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Self-checking bench for seq_alu with an arithmetic reference model
//            and a result queue checked every cycle out_valid is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
  localparam int W = 32;
  localparam longint SMAX = (longint'(1) << (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h t=%0t", name, act, want, $time);
    end
  endfunction

  // Reference model: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned ua, ub, p;
    longint sa, sb, sd;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    p  = 0;
    sd = 0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b100: e.res = ~(a | b);
      3'b101: e.res = a ^ b;
      3'b010: begin
        p = ua + ub; e.res = p[W-1:0]; e.c = p[W];
        sd = sa + sb; e.v = (sd > SMAX) || (sd < SMIN);
      end
      3'b110: begin
        p = ua - ub; e.res = p[W-1:0]; e.c = (ua >= ub);
        sd = sa - sb; e.v = (sd > SMAX) || (sd < SMIN);
      end
      3'b111: begin
        e.res = (sa < sb) ? W'(1) : W'(0); e.c = (ua >= ub);
        sd = sa - sb; e.v = (sd > SMAX) || (sd < SMIN);
      end
      default: begin
        p = ua * ub; e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.v = (e.hi != 0);
      end
    endcase
    e.z = (e.res == 0) && (e.hi == 0);
    return e;
  endfunction

  // Compare process: every cycle a result is presented it must match the
  // oldest outstanding expectation (this also proves it stays stable).
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(bus.out_valid), 64'(0));
      end else begin
        chk("result",    64'(bus.result),    64'(exp_q[0].res));
        chk("result_hi", 64'(bus.result_hi), 64'(exp_q[0].hi));
        chk("zero",      64'(bus.zero),      64'(exp_q[0].z));
        chk("cout",      64'(bus.cout),      64'(exp_q[0].c));
        chk("overflow",  64'(bus.overflow),  64'(exp_q[0].v));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  // Present an op, wait for the accept edge, then wait for out_valid.
  // Latency is counted in edges after the accept edge: 0 means out_valid is
  // already up in the cycle right after the accept.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    int d;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("in_ready_timeout", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(posedge clk); #1;
    exp_q.push_back(model(op, a, b));
    // Garbage on the inputs must not disturb the op in flight
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.op = 3'($urandom);
    bus.a  = $urandom;
    bus.b  = $urandom;
    d = 0;
    while (!bus.out_valid && d < 100) begin @(posedge clk); #1; d++; end
    chk("latency", 64'(d), (op == 3'b011) ? 64'(W + 1) : 64'(0));
  endtask

  // Hold the result under backpressure, then accept it
  task automatic finish_op(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_in_ready",  64'(bus.in_ready),  64'(0));
      chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_hs_out_valid", 64'(bus.out_valid), 64'(0));
    chk("post_hs_in_ready",  64'(bus.in_ready),  64'(1));
    chk("queue_drained",     64'(exp_q.size()),  64'(0));
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] res, input logic [W-1:0] hi,
                           input logic z, input logic c, input logic v);
    chk({name, "_res"}, 64'(bus.result),    64'(res));
    chk({name, "_hi"},  64'(bus.result_hi), 64'(hi));
    chk({name, "_z"},   64'(bus.zero),      64'(z));
    chk({name, "_c"},   64'(bus.cout),      64'(c));
    chk({name, "_v"},   64'(bus.overflow),  64'(v));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ov_seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a  = '0;
    bus.b  = '0;

    // Reset values
    #1;
    check_lit("reset", '0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_in_ready",  64'(bus.in_ready),  64'(1));
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort a multiply with reset in cycle 10 after the accept
    bus.in_valid = 1'b1; bus.op = 3'b011; bus.a = 3; bus.b = 5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_lit("abort", '0, '0, 1'b0, 1'b0, 1'b0);
    chk("abort_in_ready",  64'(bus.in_ready),  64'(1));
    chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    ov_seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) ov_seen = 1'b1; end
    chk("abort_never_valid", 64'(ov_seen), 64'(0));

    // Directed cases pinned to hand-computed values
    start_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    check_lit("add_ovf", 32'h8000_0000, '0, 1'b0, 1'b0, 1'b1);
    finish_op(0);

    start_op(3'b110, 32'd23, 32'd23);
    check_lit("sub_eq", '0, '0, 1'b1, 1'b1, 1'b0);
    finish_op(1);

    start_op(3'b111, 32'd5, 32'd7);
    check_lit("slt_5_7", 32'd1, '0, 1'b0, 1'b0, 1'b0);
    finish_op(0);

    start_op(3'b111, 32'hFFFF_FFFF, 32'd1);
    check_lit("slt_m1_1", 32'd1, '0, 1'b0, 1'b1, 1'b0);
    finish_op(0);

    start_op(3'b111, 32'd7, 32'd5);
    check_lit("slt_7_5", 32'd0, '0, 1'b1, 1'b1, 1'b0);
    finish_op(0);

    start_op(3'b011, 32'hFFFF_FFFF, 32'd2);
    check_lit("mul", 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b1);
    finish_op(2);

    start_op(3'b011, 32'd0, 32'hDEAD_BEEF);
    check_lit("mul_zero", '0, '0, 1'b1, 1'b0, 1'b0);
    finish_op(0);

    // Backpressure with a competing request held during the window
    start_op(3'b001, 32'hF0, 32'h0F);
    bus.in_valid = 1'b1; bus.op = 3'b010; bus.a = 32'h1234; bus.b = 32'h1;
    check_lit("or_bp", 32'hFF, '0, 1'b0, 1'b0, 1'b0);
    finish_op(5);
    @(posedge clk); #1;
    chk("bp_no_extra_accept", 64'(bus.out_valid), 64'(0));

    // Randomised operations against the model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 3'($urandom);
      a  = pick();
      b  = pick();
      start_op(op, a, b);
      finish_op($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
